seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
Reverse of the segment encoders: watches a time-multiplexed 8-digit seven-segment bus (shared active-low segment lines plus one-hot digit select) and recovers the displayed hex value, decimal point and blank state of every digit. Each pattern must be stable for a programmable number of cycles before it is accepted, which filters scan-edge glitches. Used as an on-chip display monitor and self-check for the display path, and as a bench scoreboard front end.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range is 1..255.
CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
seg_bus  input  8  active-low segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
dig_sel  input  8  active-high one-hot digit select; bit i = digit i.
digits  output  32  decoded hex value; digit i is in [4i+3:4i].
dps  output  8  dp lit (seg_bus bit0 == 0) for each digit.
blanks  output  8  digit i was captured with bits[7:1] = 7'b1111111.
dig_valid  output  8  digit i has been captured since reset.
err_mask  output  8  digit i was last captured with an unrecognised pattern.
frame_done  output  1  one-cycle pulse when all 8 digits have been captured in the current frame.

Behaviour:
- Reset (rst = 0, asynchronous): all outputs are 0, the input register is 0, the stability counter is 0, the frame mask is 0 and the capture-done flag is clear. After reset is released, the block first responds on the first rising edge.
- Input stage: seg_bus and dig_sel are registered every cycle (sample = registered pair).
- Stability counter:
  - If the sample equals the previous sample and dig_sel is exactly one-hot, the counter increments and saturates at STABLE_CYCLES.
  - Otherwise the counter loads 1 if the sample is one-hot, or 0 if it is not (all-zero or multi-hot select).
  - The capture-done flag clears whenever the sample changes.
- Capture: fires once per stable run, in the cycle where the counter equals STABLE_CYCLES and the capture-done flag is clear. The capture sets the flag. A pair held longer does not re-capture.
- Latency: a pair first present before edge k is reflected on the outputs after edge k+STABLE_CYCLES.
- Decode of bits[7:1] on capture of digit i:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
  - On a recognised pattern: write the value into digits[i], clear err_mask[i], clear blanks[i].
  - 1111111: blanks[i]=1, err_mask[i]=0, digits[i] unchanged.
  - Any other pattern: err_mask[i]=1, blanks[i]=0, digits[i] unchanged.
  - dps[i] is always updated from bit0. dig_valid[i] is set on every capture.
- Frame mask:
  - Each capture sets bit i of the mask.
  - When the capture makes the mask all ones, frame_done pulses for exactly one cycle (coincident with the output update) and the mask clears to 0 in the same edge.
  - Re-capturing a digit already in the mask does not pulse.
- dig_sel changing while seg_bus is held constant counts as a new pair; the counter restarts.
- Reset asserted mid-run discards the partial count and the frame mask immediately.

Optional Feature:
SEG_SCAN_DECODER_ERRCNT_EN
- Defined: adds output err_count (8 bits). It increments on each capture that sets err_mask, saturates at 255, and is cleared only by reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- STABLE_CYCLES=4; hold dig_sel=8'h01, seg_bus=8'b00000011 for 6 cycles -> digits[3:0]=0, dig_valid=8'h01, dps[0]=0. Outputs change exactly 4 edges after the first sample; only one capture occurs.
- Scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, dp lit on digit 3, 5 cycles each -> digits=32'h87654321, dps=8'h08. frame_done pulses once, on digit 7's capture.
- Digit 2 with seg_bus=8'b01010101 -> err_mask=8'h04 and digits[11:8] unchanged. Then digit 2 shows 8'b11111111 -> err_mask=0, blanks=8'h04.
- Present a 3-cycle glitch pattern between valid digits, then dig_sel=8'h03 or 8'h00 for 10 cycles -> no capture; all outputs unchanged.
- Assert rst mid-run after 7 digits are captured -> all outputs 0 asynchronously. A following full scan gives frame_done only after all 8 new captures.
- With SEG_SCAN_DECODER_ERRCNT_EN defined, 300 error captures -> err_count=255 (saturated).

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus plus decoded display state, shared by the decoder and its driver.
// SEG_SCAN_DECODER_ERRCNT_EN adds the err_count field.
interface seg_scan_decoder_if;
    logic [7:0]  seg_bus;
    logic [7:0]  dig_sel;
    logic [31:0] digits;
    logic [7:0]  dps;
    logic [7:0]  blanks;
    logic [7:0]  dig_valid;
    logic [7:0]  err_mask;
    logic        frame_done;
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    modport master (
        output seg_bus, dig_sel,
        input  digits, dps, blanks, dig_valid, err_mask, frame_done
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  seg_bus, dig_sel,
        output digits, dps, blanks, dig_valid, err_mask, frame_done
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex value, dp and blank state from a multiplexed active-low 7-seg scan bus.
// Optional SEG_SCAN_DECODER_ERRCNT_EN adds a saturating count of unrecognised-pattern captures.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // {recognised, value}; bits are segments a..g, active low
    function automatic logic [4:0] decode7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [7:0]       seg_q, sel_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [7:0]       mask_q, mask_d;
    logic [31:0]      digits_q, digits_d;
    logic [7:0]       dps_q, dps_d;
    logic [7:0]       blanks_q, blanks_d;
    logic [7:0]       valid_q, valid_d;
    logic [7:0]       err_q, err_d;
    logic             fd_q, fd_d;

    logic             same, in_onehot, capture, cap_err;
    logic [2:0]       idx;
    logic [4:0]       dec;
    logic [7:0]       mask_set;

    // The counter tracks the run length of the registered sample; the incoming pair is
    // compared against it so that a capture lands exactly STABLE_CYCLES edges after arrival.
    always_comb begin
        same      = (bus.seg_bus == seg_q) && (bus.dig_sel == sel_q);
        in_onehot = is_onehot(bus.dig_sel);
        capture   = (cnt_q == STABLE_C) && !done_q;

        if (same && in_onehot)
            cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + CNT_ONE;
        else
            cnt_d = in_onehot ? CNT_ONE : '0;

        done_d = same ? (done_q | capture) : 1'b0;

        idx = '0;
        for (int i = 0; i < 8; i++)
            if (sel_q[i]) idx = 3'(i);

        dec      = decode7(seg_q[7:1]);
        cap_err  = 1'b0;
        mask_set = mask_q | sel_q;

        digits_d = digits_q;
        dps_d    = dps_q;
        blanks_d = blanks_q;
        valid_d  = valid_q;
        err_d    = err_q;
        mask_d   = mask_q;
        fd_d     = 1'b0;

        if (capture) begin
            if (seg_q[7:1] == 7'b1111111) begin
                blanks_d[idx] = 1'b1;
                err_d[idx]    = 1'b0;
            end else if (dec[4]) begin
                digits_d[{idx, 2'b00} +: 4] = dec[3:0];
                blanks_d[idx] = 1'b0;
                err_d[idx]    = 1'b0;
            end else begin
                blanks_d[idx] = 1'b0;
                err_d[idx]    = 1'b1;
                cap_err       = 1'b1;
            end
            dps_d[idx]   = ~seg_q[0];
            valid_d[idx] = 1'b1;
            if (&mask_set) begin
                fd_d   = 1'b1;
                mask_d = '0;
            end else begin
                mask_d = mask_set;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            digits_q <= '0;
            dps_q    <= '0;
            blanks_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            seg_q    <= bus.seg_bus;
            sel_q    <= bus.dig_sel;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
            digits_q <= digits_d;
            dps_q    <= dps_d;
            blanks_q <= blanks_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.dps        = dps_q;
    assign bus.blanks     = blanks_q;
    assign bus.dig_valid  = valid_q;
    assign bus.err_mask   = err_q;
    assign bus.frame_done = fd_q;

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (cap_err && (errcnt_q != 8'hFF))
            errcnt_d = errcnt_q + 8'h01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) errcnt_q <= '0;
        else      errcnt_q <= errcnt_d;
    end

    assign bus.err_count = errcnt_q;
`else
    logic unused_cap_err;
    assign unused_cap_err = cap_err;
`endif

endmodule
